keypad_scan: RTL and testbench
==============================

# keypad_scan

Scans a 4x4 active-low matrix keypad and reports debounced key presses to the time-setting logic. It is the input-side counterpart of the multiplexed 7-segment display driver: it time-multiplexes row drive the same way the display multiplexes tube enables, and it turns column reads into a 4-bit key code with a valid/ack handshake. It sits between the board keypad pins and the controller that builds the sec/min/hour set values.

## Interface
- SCAN_PERIOD, 250000: clock cycles each row is driven (2.5 ms at 100 MHz).
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release.
- REPEAT_SCANS, 100: full scans between auto-repeat events (used only with KEYPAD_REPEAT_EN).
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset; one clock; asynchronous, active-high.
- row_out  output  4  row drive, active-low, exactly one bit low at any time.
- col_in  input  4  column sense, active-low, pulled up on board, asynchronous.
- key_code  output  4  latched code of the last accepted key, row*4 + col.
- key_valid  output  1  new key available; held until acknowledged.
- key_ack  input  1  consumer acknowledge, one-cycle pulse.
- key_held  output  1  high while a debounced key is pressed.
- overrun  output  1  sticky; a press was accepted while key_valid was still high.

## Operation
- col_in passes through a 2-flop synchronizer before use.
- Row counter 0..3; row r drives row_out = ~(1<<r) for SCAN_PERIOD cycles, then advances; 3 wraps to 0.
- Columns are sampled on the last cycle of each row slot. Samples from rows 0..3 form one scan.
- Scan result at the end of row 3:
  - NONE: no column low.
  - ONE(code): exactly one row/column pair is low.
  - MULTI: two or more pairs are low.
- Debounce FSM, evaluated once per scan end:
  - RELEASED: ONE(c) -> PRESS_CAND, with cand=c and cnt=1.
  - PRESS_CAND: the same ONE(c) increments cnt. At cnt==DEBOUNCE_SCANS -> PRESSED, which emits an event. A different code restarts with cnt=1. NONE or MULTI -> RELEASED.
  - PRESSED: NONE -> REL_CAND with cnt=1. ONE(cand) or MULTI leaves the state unchanged.
  - REL_CAND: NONE increments cnt. At cnt==DEBOUNCE_SCANS -> RELEASED. Anything else -> PRESSED.
- key_held = 1 in PRESSED and REL_CAND.
- Event with key_valid=0: key_code<=cand, key_valid<=1.
- Event with key_valid=1 and no key_ack that cycle: key_code unchanged, overrun<=1.
- Event in the same cycle as key_ack: key_code<=cand, key_valid stays 1, overrun unchanged.
- key_ack with key_valid=1 and no event: key_valid<=0 and overrun<=0 on the next edge.
- key_ack with key_valid=0 is ignored.

## Timing
- Reset values:
  - row_out = 4'b1110, key_code = 0, key_valid = 0, key_held = 0, overrun = 0.
  - FSM = RELEASED; row, slot and debounce counters = 0; synchronizer = 4'b1111.
- One full scan lasts 4*SCAN_PERIOD cycles.
- Press latency: key_valid rises 1 cycle after the scan end that completes the DEBOUNCE_SCANS-th consecutive ONE(c) scan.
- The synchronizer adds 2 cycles. Columns have SCAN_PERIOD-3 cycles to settle after a row change.
- Asserting rst mid-scan returns all state to reset values immediately. Scanning resumes at row 0 on the first edge after release.
- Counters are sized to hold their parameter value exactly, with no wrap before the compare.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In PRESSED, a repeat counter counts scan ends.
  - At REPEAT_SCANS it emits another event with the same code, following the same key_valid/overrun rules, and resets.
  - The counter clears on entering PRESSED and also counts while in REL_CAND.
- KEYPAD_REPEAT_EN undefined: no repeat logic; exactly one event per debounced press.

## Structure
- Package keypad_pkg holds:
  - the debounce state enum (RELEASED, PRESS_CAND, PRESSED, REL_CAND);
  - the scan-result encoding (NONE, ONE, MULTI);
  - KEY_W = 4 and ROWS = COLS = 4.
- Sub-module keypad_debounce contains the FSM plus debounce and repeat counters. Its inputs are the scan-end strobe and the scan result; its outputs are the event strobe, cand and key_held.
- The top level keeps the row timer, the synchronizer, scan assembly and the handshake registers.

## Test plan
Bench parameters: SCAN_PERIOD=8, DEBOUNCE_SCANS=2, REPEAT_SCANS=5.
- Reset, no keys: row_out cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, 8 cycles each; all other outputs stay 0.
- Hold row 2 / col 1 for 3 scans -> key_valid=1 and key_code=9 one cycle after the 2nd scan end. Pulse key_ack -> key_valid=0. Release for 2 scans -> key_held=0.
- Bounce: press 1 scan, release 1 scan, press 1 scan -> no key_valid.
- Two keys (codes 0 and 5) held together -> MULTI; no event and key_held stays 0.
- Press code 3 and do not ack, release, then press code 12 -> key_code stays 3 and overrun=1. Ack -> key_valid=0 and overrun=0.
- Assert rst mid-row while key_valid=1 -> all outputs return to reset values asynchronously. With KEYPAD_REPEAT_EN and code 7 held, a second event follows 5 scans after the first.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner.
// Scan-result encoding, debounce states and matrix geometry.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  typedef logic [KEY_W-1:0] key_t;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CAND,
    PRESSED,
    REL_CAND
  } db_state_t;

  typedef enum logic [1:0] {
    NONE,
    ONE,
    MULTI
  } scan_res_t;

  // 0, 1 or 2 (two or more) low columns
  function automatic logic [1:0] hits(input logic [COLS-1:0] col_n);
    logic [1:0] n;
    n = 2'd0;
    for (int i = 0; i < COLS; i++)
      if (!col_n[i] && n != 2'd2)
        n = n + 2'd1;
    return n;
  endfunction

  function automatic logic [1:0] col_idx(input logic [COLS-1:0] col_n);
    logic [1:0] c;
    c = 2'd0;
    for (int i = COLS - 1; i >= 0; i--)
      if (!col_n[i])
        c = 2'(i);
    return c;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: debounced key handshake between scanner and consumer.
// master = scanner side, slave = time-setting controller side.
interface keypad_if;
  import keypad_pkg::*;

  key_t key_code;
  logic key_valid;
  logic key_ack;
  logic key_held;
  logic overrun;

  modport master (
    output key_code, key_valid, key_held, overrun,
    input  key_ack
  );

  modport slave (
    input  key_code, key_valid, key_held, overrun,
    output key_ack
  );

endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: per-scan press/release debounce FSM.
// KEYPAD_REPEAT_EN adds auto-repeat events while a key stays held.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 100
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      scan_end,
  input  scan_res_t res,
  input  key_t      code,
  output logic      evt,
  output key_t      cand,
  output logic      key_held
);

  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_SCANS);
  localparam bit FAST = (DEBOUNCE_SCANS == 1);

  db_state_t     state;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_inc;

  assign cnt_inc = cnt + DW'(1);

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS);

  logic [RW-1:0] rep;
  logic [RW-1:0] rep_inc;

  assign rep_inc = rep + RW'(1);
`else
  logic unused_rep;
  assign unused_rep = ^REPEAT_SCANS;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RELEASED;
      cnt      <= '0;
      cand     <= '0;
      evt      <= 1'b0;
      key_held <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep      <= '0;
`endif
    end else begin
      evt <= 1'b0;
      if (scan_end) begin
        unique case (state)
          RELEASED: begin
            if (res == ONE) begin
              cand <= code;
              cnt  <= DW'(1);
              if (FAST) begin
                state    <= PRESSED;
                key_held <= 1'b1;
                evt      <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                rep      <= '0;
`endif
              end else begin
                state <= PRESS_CAND;
              end
            end
          end
          PRESS_CAND: begin
            if (res == ONE && code == cand) begin
              if (cnt_inc == DB_LAST) begin
                state    <= PRESSED;
                key_held <= 1'b1;
                evt      <= 1'b1;
                cnt      <= '0;
`ifdef KEYPAD_REPEAT_EN
                rep      <= '0;
`endif
              end else begin
                cnt <= cnt_inc;
              end
            end else if (res == ONE) begin
              cand <= code;
              cnt  <= DW'(1);
            end else begin
              state <= RELEASED;
              cnt   <= '0;
            end
          end
          PRESSED: begin
            // a different single key while held is treated as noise
            if (res == NONE) begin
              if (FAST) begin
                state    <= RELEASED;
                key_held <= 1'b0;
                cnt      <= '0;
              end else begin
                state <= REL_CAND;
                cnt   <= DW'(1);
              end
            end
          end
          REL_CAND: begin
            if (res == NONE) begin
              if (cnt_inc == DB_LAST) begin
                state    <= RELEASED;
                key_held <= 1'b0;
                cnt      <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= PRESSED;
              cnt   <= '0;
            end
          end
        endcase
`ifdef KEYPAD_REPEAT_EN
        if (state == PRESSED || state == REL_CAND) begin
          if (rep_inc == REP_LAST) begin
            rep <= '0;
            evt <= 1'b1;
          end else begin
            rep <= rep_inc;
          end
        end
`endif
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low keypad scanner with debounce and valid/ack.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_PERIOD    = 250000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 100
) (
  input  logic            clk,
  input  logic            rst,
  output logic [ROWS-1:0] row_out,
  input  logic [COLS-1:0] col_in,
  keypad_if.master        kp
);

  localparam int SW = $clog2(SCAN_PERIOD + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_PERIOD - 1);

  logic [SW-1:0]   slot;
  logic [1:0]      row;
  logic [COLS-1:0] sync1;
  logic [COLS-1:0] sync2;
  logic [1:0]      acc_n;
  key_t            acc_code;

  logic            slot_end;
  logic            scan_end;
  logic [1:0]      row_n;
  logic [2:0]      sum;
  logic [1:0]      tot_n;
  key_t            res_code;
  scan_res_t       res;

  logic            evt;
  key_t            cand;

  assign row_out  = ~(ROWS'(1) << row);
  assign slot_end = (slot == SLOT_LAST);
  assign scan_end = slot_end && (row == 2'd3);

  // fold this row's sample into the hits seen so far in the scan
  always_comb begin
    row_n    = hits(sync2);
    sum      = {1'b0, acc_n} + {1'b0, row_n};
    tot_n    = row_n;
    res_code = acc_code;
    res      = NONE;
    if (row != 2'd0)
      tot_n = (sum > 3'd2) ? 2'd2 : sum[1:0];
    if (row_n == 2'd1)
      res_code = {row, col_idx(sync2)};
    unique case (tot_n)
      2'd0:    res = NONE;
      2'd1:    res = ONE;
      default: res = MULTI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot     <= '0;
      row      <= 2'd0;
      sync1    <= '1;
      sync2    <= '1;
      acc_n    <= 2'd0;
      acc_code <= '0;
    end else begin
      sync1 <= col_in;
      sync2 <= sync1;
      if (slot_end) begin
        slot     <= '0;
        row      <= row + 2'd1;
        acc_n    <= tot_n;
        acc_code <= res_code;
      end else begin
        slot <= slot + SW'(1);
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .REPEAT_SCANS   (REPEAT_SCANS)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .scan_end (scan_end),
    .res      (res),
    .code     (res_code),
    .evt      (evt),
    .cand     (cand),
    .key_held (kp.key_held)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kp.key_code  <= '0;
      kp.key_valid <= 1'b0;
      kp.overrun   <= 1'b0;
    end else if (evt) begin
      if (!kp.key_valid || kp.key_ack) begin
        kp.key_code  <= cand;
        kp.key_valid <= 1'b1;
      end else begin
        kp.overrun <= 1'b1;
      end
    end else if (kp.key_ack && kp.key_valid) begin
      kp.key_valid <= 1'b0;
      kp.overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed checks of scan timing, debounce and handshake.
// Small period/debounce values keep every scan 32 cycles long.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic [15:0] keys;
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  keypad_if kif ();

  keypad_scan #(
    .SCAN_PERIOD    (8),
    .DEBOUNCE_SCANS (2),
    .REPEAT_SCANS   (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .row_out (row_out),
    .col_in  (col_in),
    .kp      (kif)
  );

  always #5 clk = ~clk;

  // passive matrix: a pressed key pulls its column low when its row is driven
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[r*4+c])
          col_in[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic to_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_code"},  kif.key_code,  16'h0);
    check({tag, "_valid"}, kif.key_valid, 16'h0);
    check({tag, "_held"},  kif.key_held,  16'h0);
    check({tag, "_ovr"},   kif.overrun,   16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    keys = 16'h0;
    kif.key_ack = 1'b0;
    cyc = 0;
    repeat (3) @(negedge clk);
    check("rst_row", row_out, 16'he);
    check_idle("rst");
    release_rst();

    // row sweep with no keys
    check("row_e0", row_out, 16'he);
    to_edge(7);  check("row_e7", row_out, 16'he);
    to_edge(8);  check("row_e8", row_out, 16'hd);
    to_edge(16); check("row_e16", row_out, 16'hb);
    to_edge(24); check("row_e24", row_out, 16'h7);
    to_edge(31); check("row_e31", row_out, 16'h7);
    to_edge(32); check("row_e32", row_out, 16'he);
    check_idle("idle");

    // row 2 / col 1 held for 3 scans
    keys = 16'h1 << 9;
    to_edge(96);  check("p9_pre_valid", kif.key_valid, 16'h0);
    check("p9_held", kif.key_held, 16'h1);
    to_edge(97);  check("p9_valid", kif.key_valid, 16'h1);
    check("p9_code", kif.key_code, 16'h9);
    to_edge(128); check("p9_still", kif.key_valid, 16'h1);
    check("p9_ovr", kif.overrun, 16'h0);
    kif.key_ack = 1'b1;
    to_edge(129);
    kif.key_ack = 1'b0;
    check("p9_ack", kif.key_valid, 16'h0);
    keys = 16'h0;
    to_edge(160); check("p9_relcand", kif.key_held, 16'h1);
    to_edge(192); check("p9_released", kif.key_held, 16'h0);

    // bounce: press, release, press, release one scan each
    keys = 16'h1 << 5;
    to_edge(224); keys = 16'h0;
    to_edge(225); check("bnc_valid1", kif.key_valid, 16'h0);
    check("bnc_held1", kif.key_held, 16'h0);
    to_edge(256); keys = 16'h1 << 5;
    to_edge(288); keys = 16'h0;
    to_edge(289); check("bnc_valid2", kif.key_valid, 16'h0);
    to_edge(321); check("bnc_valid3", kif.key_valid, 16'h0);
    check("bnc_held3", kif.key_held, 16'h0);

    // codes 0 and 5 together
    keys = 16'h0021;
    to_edge(417); check("multi_valid", kif.key_valid, 16'h0);
    check("multi_held", kif.key_held, 16'h0);

    // code 3 unacked, then code 12 -> overrun
    keys = 16'h1 << 3;
    to_edge(481); check("p3_valid", kif.key_valid, 16'h1);
    check("p3_code", kif.key_code, 16'h3);
    keys = 16'h0;
    to_edge(544); check("p3_released", kif.key_held, 16'h0);
    keys = 16'h1 << 12;
    to_edge(608); check("p12_pre_ovr", kif.overrun, 16'h0);
    to_edge(609); check("p12_code", kif.key_code, 16'h3);
    check("p12_ovr", kif.overrun, 16'h1);
    check("p12_valid", kif.key_valid, 16'h1);
    kif.key_ack = 1'b1;
    to_edge(610);
    kif.key_ack = 1'b0;
    check("ovr_ack_valid", kif.key_valid, 16'h0);
    check("ovr_ack_ovr", kif.overrun, 16'h0);
    keys = 16'h0;

    // code 7, then asynchronous reset mid-row
    to_edge(672);
    keys = 16'h1 << 7;
    to_edge(736); check("p7_pre_valid", kif.key_valid, 16'h0);
    to_edge(737); check("p7_valid", kif.key_valid, 16'h1);
    check("p7_code", kif.key_code, 16'h7);
    to_edge(745); check("p7_row1", row_out, 16'hd);
    #2 rst = 1'b1;
    #1;
    check("arst_row", row_out, 16'he);
    check_idle("arst");
    release_rst();

    // restart with code 7 still held
    to_edge(1);  check("rs_row_e1", row_out, 16'he);
    to_edge(8);  check("rs_row_e8", row_out, 16'hd);
    to_edge(64); check("rs_pre_valid", kif.key_valid, 16'h0);
    to_edge(65); check("rs_valid", kif.key_valid, 16'h1);
    check("rs_code", kif.key_code, 16'h7);
    kif.key_ack = 1'b1;
    to_edge(66);
    kif.key_ack = 1'b0;
    check("rs_ack", kif.key_valid, 16'h0);
    to_edge(224); check("rep_pre", kif.key_valid, 16'h0);
    to_edge(225);
`ifdef KEYPAD_REPEAT_EN
    check("rep_valid", kif.key_valid, 16'h1);
    check("rep_code", kif.key_code, 16'h7);
`else
    check("norep_valid", kif.key_valid, 16'h0);
`endif
    check("rep_ovr", kif.overrun, 16'h0);
    check("rep_held", kif.key_held, 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
